// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: reset/step defaults, FSM states, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with push, pop, clear and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push (no bypass).
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
// Ports: clk/rst (sync, active-high), push/push_dat, pop, clear (wins over push/pop),
//        count (current occupancy), head_dat (entry at the read pointer).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ENTRY_W-1:0]           push_dat,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ENTRY_W-1:0]           head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // Read-before-write: a pop frees the head slot so a full FIFO can still push.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the parent masks head data while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Owns the fetch PC, issues word reads to instruction memory and queues PC-tagged instructions for decode.
// Latency: MemReq the first cycle out of reset; a response in cycle N shows as InstrValid in cycle N+1.
// Backpressure: DecodeStall holds the head; requests stop once queued + outstanding reaches DEPTH.
// Ports: Clk/Reset (sync, active-high); Redirect/RedirectAddr from branch resolution;
//        MemReq/MemAddr/MemGnt and MemRspValid/MemRspData to instruction memory;
//        InstrValid/Instruction/InstrPC/DecodeStall to decode.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          PC_STEP         = DEFAULT_PC_STEP
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRspValid,
    input  logic [31:0] MemRspData,
    output logic        InstrValid,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    input  logic        DecodeStall
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] occupancy;
    logic [CW:0]   credit_used;
    logic [CW-1:0] in_flight;
    logic          grant;
    logic          rsp_accept;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;
    logic [31:0]   redirect_pc;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^RedirectAddr[1:0];
    assign redirect_pc         = {RedirectAddr[31:2], 2'b00};

    assign InstrValid  = (occupancy != '0);
    assign Instruction = InstrValid ? head_entry.instr : 32'h0;
    assign InstrPC     = InstrValid ? head_entry.pc    : 32'h0;
    assign MemAddr     = fetch_pc_q;

    always_comb begin
        // Queued plus outstanding is the credit count; keeping it below DEPTH
        // guarantees every granted request has a free slot when it returns.
        credit_used = {1'b0, occupancy} + {1'b0, outstanding_q};
        MemReq      = !Reset && (state_q == RUN) && !Redirect
                      && (outstanding_q < CW'(MAX_OUTSTANDING))
                      && (credit_used < (CW+1)'(DEPTH));
        grant       = MemReq && MemGnt;
        // A response with nothing outstanding is a protocol violation and is ignored.
        rsp_accept  = (state_q == RUN) && MemRspValid && (outstanding_q != '0);
        fifo_push   = rsp_accept && !Redirect;
        fifo_pop    = InstrValid && !DecodeStall && !Redirect;
        push_entry  = '{pc: rsp_pc_q, instr: MemRspData};
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        // Only one of these is ever non-zero: grants stop in FLUSH and a redirect zeroes outstanding.
        in_flight     = outstanding_q + drop_cnt_q;

        if (grant) begin
            fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
        end
        if (rsp_accept) begin
            rsp_pc_d = rsp_pc_q + 32'(PC_STEP);
        end
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp_accept);

        if ((state_q == FLUSH) && MemRspValid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_d == '0) begin
                state_d = RUN;
            end
        end

        if (Redirect) begin
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            outstanding_d = '0;
            // A response landing on the redirect cycle is wrong-path and already accounted for.
            drop_cnt_d    = in_flight - CW'(MemRspValid && (in_flight != '0));
            state_d       = (drop_cnt_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rst      (Reset),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .clear    (Redirect),
        .count    (occupancy),
        .head_dat (head_entry)
    );

endmodule
